// File: rtl/urv_pkg.sv
// Shared definitions for the uRV multi-port register file.
//   REG_ZERO    index of the hardwired-zero register
//   NRD_MAX     largest supported number of read ports
//   rf_state_t  register-file control states (idle / sequential clear)
package urv_pkg;

    localparam int REG_ZERO = 0;
    localparam int NRD_MAX  = 4;

    typedef enum logic {
        RF_IDLE  = 1'b0,
        RF_CLEAR = 1'b1
    } rf_state_t;

endpackage

// File: rtl/urv_rf_rdport.sv
// One read port of the uRV register file.
// Selects between array contents, forwarded write data and zero, then either
// presents the value directly or through a one-cycle output register.
// Ports:
//   wclk, rst     clock / asynchronous active-low reset (output register only)
//   busy          clear in progress; forces the read value to zero
//   wr_fwd        a write that will really land in the array this cycle
//   waddr, di     write address / data for forwarding
//   raddr         read address of this port
//   ram_q         array contents at raddr
//   rdata         read data (combinational or registered per REG_READ)
module urv_rf_rdport
    import urv_pkg::*;
#(
    parameter int DW       = 32,
    parameter int AW       = 5,
    parameter int REG_READ = 0,
    parameter int BYPASS   = 1,
    parameter int ZERO_R0  = 1
) (
    input  logic          wclk,
    input  logic          rst,
    input  logic          busy,
    input  logic          wr_fwd,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] di,
    input  logic [AW-1:0] raddr,
    input  logic [DW-1:0] ram_q,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] v_p0;
    logic [DW-1:0] rdata_p1;

    // stage p0: read value selection
    always_comb begin
        v_p0 = ram_q;
        if (busy) begin
            v_p0 = '0;
        end else if ((ZERO_R0 != 0) && (raddr == AW'(REG_ZERO))) begin
            v_p0 = '0;
        end else if ((BYPASS != 0) && wr_fwd && (waddr == raddr)) begin
            v_p0 = di;
        end
    end

    // stage p1: optional output register
    always_ff @(posedge wclk or negedge rst) begin
        if (!rst) begin
            rdata_p1 <= '0;
        end else begin
            rdata_p1 <= v_p0;
        end
    end

    assign rdata = (REG_READ != 0) ? rdata_p1 : v_p0;

endmodule

// File: rtl/urv_regfile_mp.sv
// uRV multi-read-port register file.
// Storage array (no reset, RAM-inferable), a write-port mux shared between
// normal writes and a sequential clear engine, and NRD read ports.
// Ports:
//   wclk   clock, all state on rising edge
//   rst    asynchronous active-low reset; always followed by a full clear
//   we, waddr, di   write port
//   raddr  packed read addresses, port k at [k*AW +: AW]
//   rdata  packed read data,      port k at [k*DW +: DW]
//   clr    clear request, sampled only while idle
//   busy   clear in progress: writes ignored, reads return 0
module urv_regfile_mp
    import urv_pkg::*;
#(
    parameter  int DW       = 32,
    parameter  int DEPTH    = 32,
    parameter  int NRD      = 2,
    parameter  int REG_READ = 0,
    parameter  int BYPASS   = 1,
    parameter  int ZERO_R0  = 1,
    localparam int AW       = $clog2(DEPTH)
) (
    input  logic              wclk,
    input  logic              rst,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DW-1:0]     di,
    input  logic [NRD*AW-1:0] raddr,
    output logic [NRD*DW-1:0] rdata,
    input  logic              clr,
    output logic              busy
);

    logic [DW-1:0] ram [DEPTH];

    rf_state_t     state;
    rf_state_t     state_nxt;
    logic [AW-1:0] clr_cnt;

    logic          wr_ok;
    logic          ram_we;
    logic [AW-1:0] ram_wa;
    logic [DW-1:0] ram_wd;

    // A write really lands only when idle and not aimed at the zero register.
    assign wr_ok = (state == RF_IDLE) && we &&
                   !((ZERO_R0 != 0) && (waddr == AW'(REG_ZERO)));

    assign busy = (state == RF_CLEAR);

    always_ff @(posedge wclk or negedge rst) begin
        if (!rst) begin
            state   <= RF_CLEAR;
            clr_cnt <= '0;
        end else begin
            state <= state_nxt;
            // Counter wraps to 0 on the last clear entry, ready for the next clear.
            if (state == RF_CLEAR) begin
                clr_cnt <= clr_cnt + 1'b1;
            end else begin
                clr_cnt <= '0;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            RF_IDLE:  if (clr) state_nxt = RF_CLEAR;
            RF_CLEAR: if (clr_cnt == AW'(DEPTH - 1)) state_nxt = RF_IDLE;
            default:  state_nxt = RF_CLEAR;
        endcase
    end

    // Single physical write port: the clear engine owns it while clearing.
    always_comb begin
        ram_we = wr_ok;
        ram_wa = waddr;
        ram_wd = di;
        if (state == RF_CLEAR) begin
            ram_we = 1'b1;
            ram_wa = clr_cnt;
            ram_wd = '0;
        end
    end

    always_ff @(posedge wclk) begin
        if (ram_we) begin
            ram[ram_wa] <= ram_wd;
        end
    end

    for (genvar k = 0; k < NRD_MAX; k++) begin : g_rd
        if (k < NRD) begin : g_port
            urv_rf_rdport #(
                .DW       (DW),
                .AW       (AW),
                .REG_READ (REG_READ),
                .BYPASS   (BYPASS),
                .ZERO_R0  (ZERO_R0)
            ) u_rdport (
                .wclk   (wclk),
                .rst    (rst),
                .busy   (busy),
                .wr_fwd (wr_ok),
                .waddr  (waddr),
                .di     (di),
                .raddr  (raddr[k*AW +: AW]),
                .ram_q  (ram[raddr[k*AW +: AW]]),
                .rdata  (rdata[k*DW +: DW])
            );
        end
    end

endmodule
